// File: rtl/spi_regfile_periph_if.sv
// SPI pin bundle between an external controller and the register-file peripheral.
// Latency: none, wires only.
// Backpressure: none; SPI has no flow control, the controller owns SCLK.
interface spi_regfile_periph_if;
  logic SCLK;
  logic COPI;
  logic nCS;
  logic CIPO;
  logic CIPO_oe;

  modport master (output SCLK, output COPI, output nCS, input CIPO, input CIPO_oe);
  modport slave  (input SCLK, input COPI, input nCS, output CIPO, output CIPO_oe);
endinterface

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 register-file peripheral: oversampled pins, write commit on well-formed frames, readback.
// Latency: register update visible SYNC_STAGES+1 clk after the raw nCS rise; CIPO 1 clk after synced edge.
// Backpressure: none; malformed frames are dropped and flagged with a frame_err pulse.
module spi_regfile_periph #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_periph_if.slave        spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int CMD_W   = 1 + ADDR_W;
  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CMD_DONE   = CNT_W'(CMD_W);

  typedef enum logic [1:0] {IDLE, CMD, DATA, FULL} state_t;

  // synchroniser chains and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ncs_prev_q,  ncs_prev_d;

  // frame state
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_W-1:0]     sr_q, sr_d;
  logic                   rw_q, rw_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   ovr_q, ovr_d;
  logic [DATA_W-1:0]      out_sr_q, out_sr_d;
  logic                   cipo_q, cipo_d;
  logic                   oe_q, oe_d;

  // register file and commit outputs
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [DATA_W-1:0]      regs_d [NUM_REGS];
  logic                   wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic                   frame_err_q, frame_err_d;

  logic sclk_cur, copi_cur, ncs_cur;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  assign sclk_cur  = sclk_sync_q[SYNC_STAGES-1];
  assign copi_cur  = copi_sync_q[SYNC_STAGES-1];
  assign ncs_cur   = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_cur & ~sclk_prev_q;
  assign sclk_fall = ~sclk_cur & sclk_prev_q;
  assign ncs_rise  = ncs_cur & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_cur & ncs_prev_q;

  // shift raw pins into the clk domain and keep one sample of history for edges
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], spi.COPI};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  spi.nCS};
    sclk_prev_d = sclk_cur;
    ncs_prev_d  = ncs_cur;
  end

  // frame FSM, shift registers, readback and commit decision
  always_comb begin
    logic [FRAME_W-1:0] sr_next;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [31:0]        cmd_addr_ext;
    logic [31:0]        addr_ext;
    logic [DATA_W-1:0]  rd_val;

    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    ovr_d       = ovr_q;
    out_sr_d    = out_sr_q;
    cipo_d      = cipo_q;
    oe_d        = oe_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;

    sr_next      = {sr_q[FRAME_W-2:0], copi_cur};
    cmd_addr     = sr_next[ADDR_W-1:0];
    cmd_addr_ext = 32'(cmd_addr);
    addr_ext     = 32'(addr_q);
    rd_val       = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr_ext == 32'(i)) rd_val = regs_q[i];
    end

    if (ncs_rise) begin
      // frame end wins over any coincident SCLK edge
      state_d = IDLE;
      cipo_d  = 1'b0;
      oe_d    = 1'b0;
      if (state_q == FULL && !ovr_q) begin
        if (rw_q && addr_ext < 32'(NUM_REGS)) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_ext == 32'(i)) regs_d[i] = sr_q[DATA_W-1:0];
          end
          wr_strobe_d = 1'b1;
          wr_addr_d   = addr_q;
        end
      end else if (state_q != IDLE) begin
        frame_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_d = CMD;
            cnt_d   = '0;
            ovr_d   = 1'b0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            sr_d  = sr_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CMD_LAST) begin
              state_d = DATA;
              rw_d    = sr_next[ADDR_W];
              addr_d  = cmd_addr;
              if (!sr_next[ADDR_W]) begin
                // read: MSB goes out now, the rest follows the SCLK falls
                out_sr_d = rd_val;
                cipo_d   = rd_val[DATA_W-1];
                oe_d     = 1'b1;
              end
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            sr_d  = sr_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == FRAME_LAST) state_d = FULL;
          end else if (sclk_fall && !rw_q && cnt_q > CMD_DONE) begin
            // the fall right after the last command bit keeps the MSB on the wire
            out_sr_d = {out_sr_q[DATA_W-2:0], 1'b0};
            cipo_d   = out_sr_q[DATA_W-2];
          end
        end
        FULL: begin
          if (sclk_rise) ovr_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      ovr_q       <= 1'b0;
      out_sr_q    <= '0;
      cipo_q      <= 1'b0;
      oe_q        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ncs_prev_q  <= ncs_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      ovr_q       <= ovr_d;
      out_sr_q    <= out_sr_d;
      cipo_q      <= cipo_d;
      oe_q        <= oe_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  // flatten the register file onto the output bus
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign spi.CIPO    = cipo_q;
  assign spi.CIPO_oe = oe_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign frame_err   = frame_err_q;

endmodule
